// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter
// Round-robin arbiter sharing the load port of a 64-bit data register between
// two requesters. The owner streams four 16-bit beats, which are packed into
// reg_data (beat k lands in bits 16k+15:16k), then reg_E and done[owner] pulse
// for one cycle.
//
// Optional feature: define REG_ARB_TIMEOUT_EN to add a stall counter that
// aborts a transaction after TIMEOUT consecutive COLLECT cycles without a
// beat transfer. The abort pulses err. Without the macro err is constant 0.
module reg_load_arbiter #(
  parameter int BEAT_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                R,
  input  logic [1:0]          req,
  input  logic [1:0]          beat_valid,
  input  logic [BEAT_W-1:0]   beat_data0,
  input  logic [BEAT_W-1:0]   beat_data1,
  output logic [1:0]          gnt,
  output logic                beat_ready,
  output logic [1:0]          done,
  output logic                reg_E,
  output logic [4*BEAT_W-1:0] reg_data,
  output logic                last_owner,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t            state;
  logic              owner;
  logic [1:0]        beat_cnt;
  logic [BEAT_W-1:0] cur_beat;
  logic              cur_valid;
  logic              xfer;
  logic              pick;

`ifdef REG_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  logic [STALL_W-1:0] stall_cnt;
`endif

  // Select the owner's beat lane, decide whether a beat moves this cycle, and
  // compute the round-robin winner used when leaving IDLE.
  always_comb begin
    cur_beat  = owner ? beat_data1 : beat_data0;
    cur_valid = beat_valid[owner];
    xfer      = (state == COLLECT) && beat_ready && cur_valid;
    if (req == 2'b11) begin
      pick = ~last_owner;
    end else begin
      pick = req[1];
    end
  end

  // Arbitration FSM with all outputs registered; reset abandons any
  // transaction in flight and gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (!R) begin
      state      <= IDLE;
      owner      <= 1'b0;
      beat_cnt   <= 2'd0;
      gnt        <= 2'b00;
      beat_ready <= 1'b0;
      done       <= 2'b00;
      reg_E      <= 1'b0;
      reg_data   <= '0;
      last_owner <= 1'b1;
`ifdef REG_ARB_TIMEOUT_EN
      stall_cnt  <= '0;
      err        <= 1'b0;
`endif
    end else begin
      reg_E <= 1'b0;
      done  <= 2'b00;
`ifdef REG_ARB_TIMEOUT_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            owner      <= pick;
            gnt        <= pick ? 2'b10 : 2'b01;
            beat_ready <= 1'b1;
            beat_cnt   <= 2'd0;
            state      <= COLLECT;
`ifdef REG_ARB_TIMEOUT_EN
            stall_cnt  <= '0;
`endif
          end
        end
        COLLECT: begin
          if (xfer) begin
            reg_data[32'(beat_cnt)*BEAT_W +: BEAT_W] <= cur_beat;
            beat_cnt <= beat_cnt + 2'd1;
`ifdef REG_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (beat_cnt == 2'd3) begin
              beat_ready <= 1'b0;
              reg_E      <= 1'b1;
              done       <= owner ? 2'b10 : 2'b01;
              state      <= WRITE;
            end
          end else begin
`ifdef REG_ARB_TIMEOUT_EN
            if (stall_cnt == STALL_LAST) begin
              err        <= 1'b1;
              gnt        <= 2'b00;
              beat_ready <= 1'b0;
              last_owner <= owner;
              stall_cnt  <= '0;
              state      <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
`endif
          end
        end
        WRITE: begin
          gnt        <= 2'b00;
          last_owner <= owner;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef REG_ARB_TIMEOUT_EN
  // No stall counter exists in this build, so err can never fire; the
  // expression is a constant 0 that also keeps TIMEOUT referenced.
  assign err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_reg_load_arbiter.sv
// tb_reg_load_arbiter
// Scoreboard bench for reg_load_arbiter: every transaction pushes its
// expected owner and word when its beats are driven, and a monitor pops and
// compares whenever the register load pulse appears. Build with
// REG_ARB_TIMEOUT_EN defined to also exercise the stall timeout.
module tb_reg_load_arbiter;

  logic        clk;
  logic        R;
  logic [1:0]  req;
  logic [1:0]  beat_valid;
  logic [15:0] beat_data0;
  logic [15:0] beat_data1;
  logic [1:0]  gnt;
  logic        beat_ready;
  logic [1:0]  done;
  logic        reg_E;
  logic [63:0] reg_data;
  logic        last_owner;
  logic        err;

  int          checks;
  int          failures;
  int          cycleCount;
  logic [64:0] expQ[$];
  logic [64:0] sbEntry;
  int          g0, g1, g2;

  reg_load_arbiter #(.BEAT_W(16), .TIMEOUT(15)) dut (
    .clk        (clk),
    .R          (R),
    .req        (req),
    .beat_valid (beat_valid),
    .beat_data0 (beat_data0),
    .beat_data1 (beat_data1),
    .gnt        (gnt),
    .beat_ready (beat_ready),
    .done       (done),
    .reg_E      (reg_E),
    .reg_data   (reg_data),
    .last_owner (last_owner),
    .err        (err)
  );

  // Free-running clock and a cycle counter used for latency measurements.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: each register load must match the oldest queued word.
  always @(negedge clk) begin
    if (R === 1'b1 && reg_E === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected_regE", 64'd1, 64'd0);
      end else begin
        sbEntry = expQ.pop_front();
        checkOutput("sb_data", reg_data, sbEntry[63:0]);
        checkOutput("sb_done", {62'd0, done}, sbEntry[64] ? 64'd2 : 64'd1);
      end
    end
  end

  // Wait for the grant, stream four beats for requester r (with an optional
  // stall after beat stallAfter), then check the WRITE cycle and the cycle
  // after it. dropReq clears all requests once the grant is seen.
  task automatic applyStimulus(input int r, input logic [63:0] word, input int stallAfter,
                               input int stallN, input int expLat, input bit dropReq,
                               output int grantCycle);
    int n;
    logic [1:0] oh;
    oh = (r == 1) ? 2'b10 : 2'b01;
    n = 0;
    while (gnt == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("grant", {62'd0, gnt}, {62'd0, oh});
    checkOutput("beat_ready_collect", {63'd0, beat_ready}, 64'd1);
    grantCycle = cycleCount;
    if (dropReq) req = 2'b00;
    expQ.push_back({r[0], word});
    for (int k = 0; k < 4; k++) begin
      beat_valid[r] = 1'b1;
      if (r == 1) beat_data1 = word[16*k +: 16];
      else        beat_data0 = word[16*k +: 16];
      tick();
      beat_valid[r] = 1'b0;
      if (k == stallAfter) repeat (stallN) tick();
    end
    checkOutput("reg_E_write", {63'd0, reg_E}, 64'd1);
    checkOutput("done_write", {62'd0, done}, {62'd0, oh});
    checkOutput("latency", 64'(cycleCount - grantCycle), 64'(expLat));
    checkOutput("beat_ready_write", {63'd0, beat_ready}, 64'd0);
    tick();
    checkOutput("gnt_clear", {62'd0, gnt}, 64'd0);
    checkOutput("reg_E_after", {63'd0, reg_E}, 64'd0);
    checkOutput("last_owner", {63'd0, last_owner}, 64'(r));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    cycleCount = 0;
    R = 1'b0;
    req = 2'b11;
    beat_valid = 2'b00;
    beat_data0 = 16'h0;
    beat_data1 = 16'h0;

    // Reset held for two cycles with both requests pending.
    tick();
    tick();
    checkOutput("rst_gnt", {62'd0, gnt}, 64'd0);
    checkOutput("rst_reg_E", {63'd0, reg_E}, 64'd0);
    checkOutput("rst_done", {62'd0, done}, 64'd0);
    checkOutput("rst_beat_ready", {63'd0, beat_ready}, 64'd0);
    checkOutput("rst_reg_data", reg_data, 64'd0);
    checkOutput("rst_err", {63'd0, err}, 64'd0);
    checkOutput("rst_last_owner", {63'd0, last_owner}, 64'd1);
    R = 1'b1;
    tick();
    checkOutput("rst_release_gnt", {62'd0, gnt}, 64'd1);
    req = 2'b00;
    R = 1'b0;
    tick();
    R = 1'b1;
    tick();

    // Single requester 0, beats back to back.
    req = 2'b01;
    applyStimulus(0, 64'h4444_3333_2222_1111, -1, 0, 4, 1'b1, g0);

    // Requester 1 with a 3-cycle stall while requester 0 floods junk beats.
    beat_valid[0] = 1'b1;
    beat_data0 = 16'hDEAD;
    req = 2'b10;
    applyStimulus(1, 64'h8888_7777_6666_5555, 1, 3, 7, 1'b1, g0);
    tick();
    checkOutput("no_req_no_gnt", {62'd0, gnt}, 64'd0);
    beat_valid = 2'b00;

    // Both requesters held high: grants alternate 01, 10, 01.
    req = 2'b11;
    applyStimulus(0, 64'hA0A1_A2A3_A4A5_A6A7, -1, 0, 4, 1'b0, g0);
    applyStimulus(1, 64'hB0B1_B2B3_B4B5_B6B7, -1, 0, 4, 1'b0, g1);
    applyStimulus(0, 64'hC0C1_C2C3_C4C5_C6C7, -1, 0, 4, 1'b1, g2);
    checkOutput("spacing_01", {63'd0, (g1 - g0) >= 6}, 64'd1);
    checkOutput("spacing_12", {63'd0, (g2 - g1) >= 6}, 64'd1);

    // Reset in cycle 3 of COLLECT aborts the transaction.
    req = 2'b11;
    for (int n = 0; n < 20 && gnt == 2'b00; n++) tick();
    beat_valid[0] = 1'b1;
    beat_data0 = 16'h1234;
    tick();
    tick();
    R = 1'b0;
    tick();
    beat_valid = 2'b00;
    checkOutput("abort_gnt", {62'd0, gnt}, 64'd0);
    checkOutput("abort_reg_E", {63'd0, reg_E}, 64'd0);
    checkOutput("abort_done", {62'd0, done}, 64'd0);
    checkOutput("abort_reg_data", reg_data, 64'd0);
    R = 1'b1;
    tick();
    checkOutput("abort_regrant", {62'd0, gnt}, 64'd1);
    req = 2'b00;
    R = 1'b0;
    tick();
    R = 1'b1;
    tick();

`ifdef REG_ARB_TIMEOUT_EN
    // Two beats then silence: timeout abort, other requester served next.
    req = 2'b11;
    for (int n = 0; n < 20 && gnt == 2'b00; n++) tick();
    checkOutput("to_grant", {62'd0, gnt}, 64'd1);
    g0 = cycleCount;
    req = 2'b10;
    beat_valid[0] = 1'b1;
    beat_data0 = 16'h5A5A;
    tick();
    tick();
    beat_valid = 2'b00;
    for (int n = 0; n < 40 && err !== 1'b1; n++) tick();
    checkOutput("to_err", {63'd0, err}, 64'd1);
    checkOutput("to_cycles", 64'(cycleCount - g0), 64'd17);
    checkOutput("to_reg_E", {63'd0, reg_E}, 64'd0);
    checkOutput("to_gnt", {62'd0, gnt}, 64'd0);
    checkOutput("to_last_owner", {63'd0, last_owner}, 64'd0);
    tick();
    checkOutput("to_next_grant", {62'd0, gnt}, 64'd2);
    req = 2'b00;
    R = 1'b0;
    tick();
    R = 1'b1;
    tick();
`endif

    checkOutput("sb_drained", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_load_arbiter.md
# reg_load_arbiter

- Shares the load port of the 64-bit data register between two requesters.
- Each requester has a 16-bit beat interface. The arbiter grants one requester at a time (round-robin) and assembles four 16-bit beats into a 64-bit word.
- Once all four beats are in, it drives the register's enable and data inputs for one cycle.
- Sits directly upstream of the register: `reg_E` connects to its `E`, `reg_data` to its `data`.

## Interface
Parameters:
- `BEAT_W`, 16, width of one beat; register width is fixed at 4*BEAT_W = 64.
- `TIMEOUT`, 15, consecutive stall cycles allowed in COLLECT before abort (used only with the macro).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `R`  in  1  synchronous, active-low reset.
- `req`  in  2  per-requester request level; bit i = requester i.
- `beat_valid`  in  2  per-requester beat valid.
- `beat_data0`  in  16  beat data, requester 0.
- `beat_data1`  in  16  beat data, requester 1.
- `gnt`  out  2  one-hot grant, registered.
- `beat_ready`  out  1  arbiter accepts a beat from the granted requester this cycle.
- `done`  out  2  one-cycle pulse to the owner when its word is written.
- `reg_E`  out  1  register load enable, one-cycle pulse.
- `reg_data`  out  64  assembled word to the register.
- `last_owner`  out  1  index of the requester that last completed or aborted.
- `err`  out  1  timeout abort pulse; constant 0 when the macro is absent.

## Operation
- Reset (R=0 at a rising edge): all outputs 0, state IDLE, beat counter 0. Round-robin priority is set to requester 0 (`last_owner`=1).
- Three states: IDLE, COLLECT, WRITE.
- **IDLE**
  - If any `req` bit is high, pick the owner. Single request: that requester. Both requesting: the requester != `last_owner`.
  - Next cycle: `gnt` one-hot set, state COLLECT, beat counter 0.
  - No request: stay in IDLE.
- **COLLECT**
  - `beat_ready`=1.
  - A beat transfers when `beat_valid[owner]` && `beat_ready` are both high.
  - Beat k (k = 0..3) is stored in `reg_data[16k+15:16k]`; the counter increments.
  - Transfer of beat 3 moves the state to WRITE.
  - `beat_valid` of the non-owner is ignored.
  - `req` is sampled only in IDLE; deasserting `req` mid-COLLECT does not cancel the transaction.
- **WRITE**
  - `reg_E`=1 and `done[owner]`=1 for exactly one cycle; `beat_ready`=0.
  - `reg_data` holds the complete word.
  - `last_owner` updates to the owner; state returns to IDLE.
  - `gnt` clears on the cycle after WRITE.
- Simultaneous events: a requester re-asserting `req` in WRITE is seen in the following IDLE cycle. Round-robin then favours the other requester if both are pending.
- `reg_data` holds its last value outside WRITE; the register only captures it on `reg_E`.
- Reset in any state aborts the transaction immediately: no `reg_E`, no `done`, outputs as at reset.

## Timing
- Cycle 0: `req` sampled in IDLE.
- Cycle 1: `gnt` high, COLLECT.
- Best case (`beat_valid` held high), beats transfer in cycles 1–4.
- Cycle 5: WRITE, `reg_E` pulse; the register updates at the end of cycle 5.
- Cycle 6: IDLE; the earliest next `gnt` is cycle 7.
- Minimum grant-to-grant spacing is 6 cycles. There is always at least one IDLE cycle between transactions.
- Stalls (`beat_valid` low) extend COLLECT one cycle each.

## Configuration
- Macro `REG_ARB_TIMEOUT_EN`.
- **Defined**
  - A stall counter counts consecutive COLLECT cycles with no beat transfer; it resets on every transfer.
  - When the counter reaches `TIMEOUT`, the transaction aborts: `err` pulses one cycle, `gnt` clears and the state returns to IDLE.
  - On abort there is no `reg_E` and no `done`; `last_owner` updates to the aborted owner.
  - Partially collected data is discarded.
- **Undefined**
  - COLLECT waits indefinitely; `err` is tied to 0; no stall counter is present.

## Test plan
- Reset: R=0 for 2 cycles with `req`=2'b11 → all outputs 0, no `gnt`. Release R → `gnt`=2'b01 one cycle later.
- Single requester 0, beats 16'h1111, 16'h2222, 16'h3333, 16'h4444 back-to-back → `reg_E` in cycle 5 with `reg_data`=64'h4444_3333_2222_1111, `done`=2'b01.
- Both `req` held high continuously → grants alternate 01, 10, 01, each transaction writes its own data, and consecutive grants are ≥6 cycles apart.
- Requester 1 granted; requester 0 drives `beat_valid` and data 16'hDEAD throughout; requester 1 stalls 3 cycles between beats → only requester 1 data written, `reg_E` in cycle 8.
- R=0 asserted in cycle 3 of COLLECT → no `reg_E`/`done`, outputs 0 next cycle, `gnt`=2'b01 one cycle after release if `req`=2'b11.
- With `REG_ARB_TIMEOUT_EN`, `TIMEOUT`=15: two beats then `beat_valid` low → `err` pulse after 15 stall cycles, no `reg_E`, `gnt` 0. Pending other requester granted next.
